// File: rtl/write_sequencer_if.sv
// Write-path bus of the frame write sequencer: pipeline strobes in,
// BMP buffer writes and dump handshake out.
interface write_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 21
) ();
    logic                  start;
    logic                  horizontal_Pulse;
    logic                  wr_Enable;
    logic [ADDR_WIDTH-1:0] wr_Addr_Even;
    logic [ADDR_WIDTH-1:0] wr_Addr_Odd;
    logic [15:0]           row_Index;
    logic [15:0]           col_Index;
    logic                  dump_Req;
    logic                  dump_Ack;
    logic                  sig_Write_Done;
    logic                  overflow_Error;

    // Sequencer side
    modport master (
        input  start, horizontal_Pulse, dump_Ack,
        output wr_Enable, wr_Addr_Even, wr_Addr_Odd, row_Index, col_Index,
               dump_Req, sig_Write_Done, overflow_Error
    );

    // Pipeline / buffer / BMP writer side
    modport slave (
        output start, horizontal_Pulse, dump_Ack,
        input  wr_Enable, wr_Addr_Even, wr_Addr_Odd, row_Index, col_Index,
               dump_Req, sig_Write_Done, overflow_Error
    );
endinterface

// File: rtl/write_sequencer.sv
// Frame write sequencer: turns pixel-pair strobes into bottom-up, BGR byte
// addresses for the BMP buffer, then runs the dump req/ack handshake.
module write_sequencer #(
    parameter int unsigned IMAGE_WIDTH  = 768,
    parameter int unsigned IMAGE_HEIGHT = 512,
    parameter int unsigned ADDR_WIDTH   = 21
) (
    input logic               clk,
    input logic               reset,
    write_sequencer_if.master bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DUMP    = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam int unsigned ROW_BYTES_I = IMAGE_WIDTH * 3;
    localparam int unsigned BASE_INIT_I = (IMAGE_HEIGHT - 1) * IMAGE_WIDTH * 3;

    localparam logic [ADDR_WIDTH-1:0] ROW_BYTES = ADDR_WIDTH'(ROW_BYTES_I);
    localparam logic [ADDR_WIDTH-1:0] BASE_INIT = ADDR_WIDTH'(BASE_INIT_I);
    localparam logic [ADDR_WIDTH-1:0] PAIR_STEP = ADDR_WIDTH'(6);
    localparam logic [ADDR_WIDTH-1:0] PIX_STEP  = ADDR_WIDTH'(3);
    localparam logic [15:0]           COL_LAST  = 16'(IMAGE_WIDTH - 2);
    localparam logic [15:0]           ROW_LAST  = 16'(IMAGE_HEIGHT - 1);

    logic [1:0]            state_q,     state_d;
    logic [15:0]           row_q,       row_d;
    logic [15:0]           col_q,       col_d;
    logic [ADDR_WIDTH-1:0] base_q,      base_d;
    logic [ADDR_WIDTH-1:0] col_off_q,   col_off_d;
    logic                  wr_en_q,     wr_en_d;
    logic [ADDR_WIDTH-1:0] addr_even_q, addr_even_d;
    logic [ADDR_WIDTH-1:0] addr_odd_q,  addr_odd_d;
    logic [15:0]           row_idx_q,   row_idx_d;
    logic [15:0]           col_idx_q,   col_idx_d;
    logic                  dump_req_q,  dump_req_d;
    logic                  done_q,      done_d;
    logic                  ovf_q,       ovf_d;

    // Next-state and next-output logic; column offset runs in steps of 6
    // bytes so the address needs only an adder, never a multiplier.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        base_d      = base_q;
        col_off_d   = col_off_q;
        wr_en_d     = 1'b0;
        addr_even_d = addr_even_q;
        addr_odd_d  = addr_odd_q;
        row_idx_d   = row_idx_q;
        col_idx_d   = col_idx_q;
        dump_req_d  = dump_req_q;
        done_d      = done_q;
        ovf_d       = ovf_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d   = ST_CAPTURE;
                    row_d     = 16'd0;
                    col_d     = 16'd0;
                    col_off_d = '0;
                    base_d    = BASE_INIT;
                    ovf_d     = 1'b0;
                    done_d    = 1'b0;
                end else if (bus.horizontal_Pulse && (state_q == ST_DONE)) begin
                    ovf_d = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (bus.horizontal_Pulse) begin
                    wr_en_d     = 1'b1;
                    addr_even_d = base_q + col_off_q;
                    addr_odd_d  = base_q + col_off_q + PIX_STEP;
                    row_idx_d   = row_q;
                    col_idx_d   = col_q;
                    if (col_q == COL_LAST) begin
                        col_d     = 16'd0;
                        col_off_d = '0;
                        row_d     = row_q + 16'd1;
                        base_d    = base_q - ROW_BYTES;
                        if (row_q == ROW_LAST) begin
                            state_d    = ST_DUMP;
                            dump_req_d = 1'b1;
                        end
                    end else begin
                        col_d     = col_q + 16'd2;
                        col_off_d = col_off_q + PAIR_STEP;
                    end
                end
            end
            default: begin
                if (bus.horizontal_Pulse) begin
                    ovf_d = 1'b1;
                end
                if (bus.dump_Ack) begin
                    state_d    = ST_DONE;
                    dump_req_d = 1'b0;
                    done_d     = 1'b1;
                end
            end
        endcase
    end

    // State and registered outputs; reset abandons any partial frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            row_q       <= 16'd0;
            col_q       <= 16'd0;
            base_q      <= '0;
            col_off_q   <= '0;
            wr_en_q     <= 1'b0;
            addr_even_q <= '0;
            addr_odd_q  <= '0;
            row_idx_q   <= 16'd0;
            col_idx_q   <= 16'd0;
            dump_req_q  <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            base_q      <= base_d;
            col_off_q   <= col_off_d;
            wr_en_q     <= wr_en_d;
            addr_even_q <= addr_even_d;
            addr_odd_q  <= addr_odd_d;
            row_idx_q   <= row_idx_d;
            col_idx_q   <= col_idx_d;
            dump_req_q  <= dump_req_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.wr_Enable      = wr_en_q;
    assign bus.wr_Addr_Even   = addr_even_q;
    assign bus.wr_Addr_Odd    = addr_odd_q;
    assign bus.row_Index      = row_idx_q;
    assign bus.col_Index      = col_idx_q;
    assign bus.dump_Req       = dump_req_q;
    assign bus.sig_Write_Done = done_q;
    assign bus.overflow_Error = ovf_q;
endmodule
